seven_segment_decoder: RTL and testbench
========================================

// Module: seven_segment_decoder
// PURPOSE
//  Receive side of the two-digit 7-segment bus: samples tens/ones segment patterns
//  (bit6=a .. bit0=g, active-high), filters glitches, decodes them back to a binary
//  value 0..30 and delivers each settled value once over a valid/ready handshake.
//  Sits between a scanned/captured display bus and the game-control logic.
// PARAMETERS
//  STABLE_CYCLES  4  consecutive identical samples required before a pattern pair is settled (>=2)
//  CNT_W          3  width of the settle counter; must hold STABLE_CYCLES
// PORTS
//  clk           in   1  single clock, rising edge
//  reset_n       in   1  asynchronous, active-low reset
//  tens_digit    in   7  tens segment pattern
//  ones_digit    in   7  ones segment pattern
//  out_number    out  5  decoded value 0..30 (0 when out_err=1)
//  out_err       out  1  pattern pair not a legal code
//  out_valid     out  1  out_number/out_err hold a result
//  out_ready     in   1  consumer accepts on clk edge when out_valid&&out_ready
//  err_count     out  8  (DECODE_ERR_CNT_EN only) saturating count of emitted errors
// BEHAVIOUR
//  Reset: every output, sample regs, counter, pending slot = 0; first_flag = 1.
//  Sample stage: {tens,ones} registered every edge. cnt <= 1 if new sample != previous sample,
//   else cnt+1 saturating at STABLE_CYCLES. Settle event: single cycle in which cnt reaches
//   STABLE_CYCLES; no repeat until the sample changes.
//  Latency: pattern first captured on edge 1, held -> settle after edge STABLE_CYCLES,
//   out_valid=1 after edge STABLE_CYCLES+1.
//  Decode tens: 0000000->0, 0110000->1, 1101101->2, 1111001->3; anything else = error.
//  Decode ones: 0 1111110, 1 0110000, 2 1101101, 3 1111001, 4 0110011, 5 1011011,
//   6 1011111, 7 1110000, 8 1111111, 9 1110011; anything else (incl. blank) = error.
//  Range: tens=3 legal only with ones=0 (value 30); else error. value = tens*10+ones, 5-bit.
//  Error result: out_err=1, out_number=0; errors are delivered like normal results.
//  Dedup: settle event emits only if pattern pair != last emitted pair, or first_flag=1
//   (cleared on first emit). Glitch A->B->A with B shorter than STABLE_CYCLES emits nothing.
//  States: EMPTY (out_valid=0), FULL (out_valid=1, no pending), FULL_PEND (out_valid=1, pending).
//   EMPTY: emit -> output regs load, FULL.
//   FULL: accept & no emit -> EMPTY; accept & emit -> output loads new result same edge, FULL;
//    emit & no accept -> pending slot loads, FULL_PEND.
//   FULL_PEND: accept -> output loads pending (or new emit if same edge; latest wins), FULL;
//    emit & no accept -> pending overwritten (latest wins).
//  While out_valid=1 and not accepted, out_number/out_err must not change.
//  out_ready ignored when out_valid=0. Reset mid-operation discards output and pending data.
// CONFIGURATION
//  DECODE_ERR_CNT_EN defined: err_count port present; +1 on each accepted transfer with
//   out_err=1, saturates at 255, reset to 0. Undefined: port and counter absent, no other change.
// TESTING
//  Reset then tens=0000000, ones=1110011 held, out_ready=1 -> out_valid on edge 5, out_number=9, out_err=0.
//  tens=1101101, ones=1011011 held -> single result 25; holding further gives no second out_valid.
//  tens=1111001, ones=0110000 -> out_err=1, out_number=0; tens=1111001, ones=1111110 -> 30.
//  Pattern for 12, then 17 for 2 cycles, then back to 12 -> only one transfer (12).
//  out_ready=0; settle 4 then 7 then 8 -> 4 held stable; on accept, next result 8 (7 dropped).
//  With DECODE_ERR_CNT_EN, 300 accepted error results -> err_count=255; reset_n low mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/seven_segment_decoder.sv
// Receive side of the two-digit 7-segment bus: glitch filter, decode to 0..30, valid/ready delivery.
// Optional feature macro: DECODE_ERR_CNT_EN adds the saturating err_count output.
module seven_segment_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] tens_digit,
    input  logic [6:0] ones_digit,
    output logic [4:0] out_number,
    output logic       out_err,
    output logic       out_valid,
    input  logic       out_ready
`ifdef DECODE_ERR_CNT_EN
    ,
    output logic [7:0] err_count
`endif
);

    localparam logic [CNT_W-1:0] STABLE_CNT = CNT_W'(STABLE_CYCLES);

    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        FULL      = 2'd1,
        FULL_PEND = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [13:0]      sample_q, sample_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             settle_q, settle_d;
    logic             first_q, first_d;
    logic [13:0]      last_q, last_d;
    logic [4:0]       out_number_q, out_number_d;
    logic             out_err_q, out_err_d;
    logic [4:0]       pend_number_q, pend_number_d;
    logic             pend_err_q, pend_err_d;

    logic [1:0]       tens_val;
    logic [3:0]       ones_val;
    logic             tens_ok, ones_ok;
    logic             dec_err;
    logic [4:0]       dec_number;
    logic             emit, accept;

    // Settle fires once, on the edge where the run of identical samples first reaches STABLE_CYCLES.
    always_comb begin
        sample_d = {tens_digit, ones_digit};
        if (sample_d != sample_q) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q == STABLE_CNT) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        settle_d = (cnt_d == STABLE_CNT) && (cnt_q != STABLE_CNT);
    end

    always_comb begin
        tens_val = 2'd0;
        tens_ok  = 1'b1;
        case (sample_q[13:7])
            7'b0000000: tens_val = 2'd0;
            7'b0110000: tens_val = 2'd1;
            7'b1101101: tens_val = 2'd2;
            7'b1111001: tens_val = 2'd3;
            default:    tens_ok  = 1'b0;
        endcase

        ones_val = 4'd0;
        ones_ok  = 1'b1;
        case (sample_q[6:0])
            7'b1111110: ones_val = 4'd0;
            7'b0110000: ones_val = 4'd1;
            7'b1101101: ones_val = 4'd2;
            7'b1111001: ones_val = 4'd3;
            7'b0110011: ones_val = 4'd4;
            7'b1011011: ones_val = 4'd5;
            7'b1011111: ones_val = 4'd6;
            7'b1110000: ones_val = 4'd7;
            7'b1111111: ones_val = 4'd8;
            7'b1110011: ones_val = 4'd9;
            default:    ones_ok  = 1'b0;
        endcase

        dec_err    = !tens_ok || !ones_ok || ((tens_val == 2'd3) && (ones_val != 4'd0));
        dec_number = dec_err ? 5'd0 : (5'(tens_val) * 5'd10 + 5'(ones_val));
    end

    assign emit   = settle_q && (first_q || (sample_q != last_q));
    assign accept = (state_q != EMPTY) && out_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (emit) state_d = FULL;
            end
            FULL: begin
                if (accept && !emit)      state_d = EMPTY;
                else if (emit && !accept) state_d = FULL_PEND;
            end
            FULL_PEND: begin
                if (accept) state_d = FULL;
            end
            default: state_d = EMPTY;
        endcase
    end

    // A fresh result arriving on the accept edge supersedes anything pending (latest wins).
    always_comb begin
        out_number_d  = out_number_q;
        out_err_d     = out_err_q;
        pend_number_d = pend_number_q;
        pend_err_d    = pend_err_q;
        first_d       = first_q;
        last_d        = last_q;

        if (emit) begin
            first_d = 1'b0;
            last_d  = sample_q;
        end

        case (state_q)
            EMPTY: begin
                if (emit) begin
                    out_number_d = dec_number;
                    out_err_d    = dec_err;
                end
            end
            FULL: begin
                if (emit && accept) begin
                    out_number_d = dec_number;
                    out_err_d    = dec_err;
                end else if (emit) begin
                    pend_number_d = dec_number;
                    pend_err_d    = dec_err;
                end
            end
            FULL_PEND: begin
                if (accept && emit) begin
                    out_number_d = dec_number;
                    out_err_d    = dec_err;
                end else if (accept) begin
                    out_number_d = pend_number_q;
                    out_err_d    = pend_err_q;
                end else if (emit) begin
                    pend_number_d = dec_number;
                    pend_err_d    = dec_err;
                end
            end
            default: begin
                out_number_d = out_number_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sample_q      <= '0;
            cnt_q         <= '0;
            settle_q      <= 1'b0;
            first_q       <= 1'b1;
            last_q        <= '0;
            out_number_q  <= '0;
            out_err_q     <= 1'b0;
            pend_number_q <= '0;
            pend_err_q    <= 1'b0;
        end else begin
            sample_q      <= sample_d;
            cnt_q         <= cnt_d;
            settle_q      <= settle_d;
            first_q       <= first_d;
            last_q        <= last_d;
            out_number_q  <= out_number_d;
            out_err_q     <= out_err_d;
            pend_number_q <= pend_number_d;
            pend_err_q    <= pend_err_d;
        end
    end

    always_comb begin
        out_valid  = (state_q != EMPTY);
        out_number = out_number_q;
        out_err    = out_err_q;
    end

`ifdef DECODE_ERR_CNT_EN
    logic [7:0] err_count_q, err_count_d;

    always_comb begin
        err_count_d = err_count_q;
        if (accept && out_err_q && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_seven_segment_decoder.sv
// Self-checking bench for seven_segment_decoder: directed scenarios plus randomized patterns
// compared against a behavioural model of filtering, dedup and latest-wins delivery.
module tb_seven_segment_decoder;

    localparam int STABLE = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [6:0] tens_digit;
    logic [6:0] ones_digit;
    logic [4:0] out_number;
    logic       out_err;
    logic       out_valid;
    logic       out_ready;
`ifdef DECODE_ERR_CNT_EN
    logic [7:0] err_count;
`endif

    always #5 clk = ~clk;

    seven_segment_decoder #(.STABLE_CYCLES(STABLE), .CNT_W(3)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .tens_digit (tens_digit),
        .ones_digit (ones_digit),
        .out_number (out_number),
        .out_err    (out_err),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
`ifdef DECODE_ERR_CNT_EN
        ,
        .err_count  (err_count)
`endif
    );

    int checks   = 0;
    int failures = 0;

    logic [6:0] onesSeg [10];
    logic [6:0] tensSeg [4];

    // Reference model state: run length of identical samples, last emitted pair,
    // one displayed result and at most one newest waiting result.
    logic [13:0] mPrev;
    logic [13:0] mLast;
    int          mRun;
    bit          mSettle;
    bit          mFirst;
    bit          mHasDisp;
    bit          mHasWait;
    int          mDispNum;
    bit          mDispErr;
    int          mWaitNum;
    bit          mWaitErr;
    int          mErrCnt;

    int          dutAccepts;
    int          lastAcceptedNum;
    bit          lastAcceptedErr;

    function automatic void decodeRef(input logic [13:0] pair, output int num, output bit err);
        int t;
        int o;
        t = -1;
        o = -1;
        for (int i = 0; i < 4; i++) if (tensSeg[i] == pair[13:7]) t = i;
        for (int i = 0; i < 10; i++) if (onesSeg[i] == pair[6:0]) o = i;
        if (t < 0 || o < 0 || (t * 10 + o) > 30) begin
            err = 1'b1;
            num = 0;
        end else begin
            err = 1'b0;
            num = t * 10 + o;
        end
    endfunction

    task automatic modelReset();
        mPrev    = '0;
        mLast    = '0;
        mRun     = 0;
        mSettle  = 1'b0;
        mFirst   = 1'b1;
        mHasDisp = 1'b0;
        mHasWait = 1'b0;
        mDispNum = 0;
        mDispErr = 1'b0;
        mWaitNum = 0;
        mWaitErr = 1'b0;
        mErrCnt  = 0;
    endtask

    task automatic modelStep(input logic [13:0] inPair, input bit ready);
        bit acc;
        bit emit;
        int n;
        bit e;
        acc  = mHasDisp && ready;
        emit = 1'b0;
        n    = 0;
        e    = 1'b0;
        if (acc && mDispErr && mErrCnt < 255) mErrCnt++;
        if (mSettle && (mFirst || mPrev != mLast)) begin
            decodeRef(mPrev, n, e);
            emit   = 1'b1;
            mLast  = mPrev;
            mFirst = 1'b0;
        end
        if (acc) mHasDisp = 1'b0;
        if (emit) begin
            mHasWait = 1'b1;
            mWaitNum = n;
            mWaitErr = e;
        end
        if (!mHasDisp && mHasWait) begin
            mHasDisp = 1'b1;
            mDispNum = mWaitNum;
            mDispErr = mWaitErr;
            mHasWait = 1'b0;
        end
        mRun    = (inPair == mPrev) ? mRun + 1 : 1;
        mSettle = (mRun == STABLE);
        mPrev   = inPair;
    endtask

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, "/valid"}, 32'(out_valid), 32'(mHasDisp));
        if (mHasDisp) begin
            checkVal({tag, "/number"}, 32'(out_number), 32'(mDispNum));
            checkVal({tag, "/err"}, 32'(out_err), 32'(mDispErr));
        end
`ifdef DECODE_ERR_CNT_EN
        checkVal({tag, "/errcnt"}, 32'(err_count), 32'(mErrCnt));
`endif
    endtask

    // Called at a falling edge; each cycle drives inputs, steps the model on the rising edge
    // and compares on the following falling edge.
    task automatic applyStimulus(input logic [6:0] t, input logic [6:0] o, input logic r,
                                 input int cycles, input string tag);
        for (int i = 0; i < cycles; i++) begin
            tens_digit = t;
            ones_digit = o;
            out_ready  = r;
            if (out_valid && out_ready) begin
                dutAccepts++;
                lastAcceptedNum = int'(out_number);
                lastAcceptedErr = out_err;
            end
            @(posedge clk);
            modelStep({t, o}, r);
            @(negedge clk);
            checkOutput(tag);
        end
    endtask

    initial begin
        int a0;
        logic [6:0] rt;
        logic [6:0] ro;
        int hold;

        onesSeg = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1110011};
        tensSeg = '{7'b0000000, 7'b0110000, 7'b1101101, 7'b1111001};

        reset_n    = 1'b0;
        tens_digit = '0;
        ones_digit = '0;
        out_ready  = 1'b0;
        dutAccepts = 0;
        lastAcceptedNum = 0;
        lastAcceptedErr = 1'b0;
        modelReset();
        repeat (2) @(negedge clk);
        checkOutput("reset");
        checkVal("reset/number0", 32'(out_number), 32'd0);
        checkVal("reset/err0", 32'(out_err), 32'd0);
        reset_n = 1'b1;

        // Value 9: valid appears exactly after the fifth edge
        applyStimulus(tensSeg[0], onesSeg[9], 1'b1, 4, "t9");
        checkVal("t9/notYet", 32'(out_valid), 32'd0);
        applyStimulus(tensSeg[0], onesSeg[9], 1'b1, 1, "t9");
        checkVal("t9/edge5valid", 32'(out_valid), 32'd1);
        checkVal("t9/edge5number", 32'(out_number), 32'd9);
        checkVal("t9/edge5err", 32'(out_err), 32'd0);
        applyStimulus(tensSeg[0], onesSeg[9], 1'b1, 2, "t9");

        a0 = dutAccepts;
        applyStimulus(tensSeg[2], onesSeg[5], 1'b1, 12, "t25");
        checkVal("t25/transfers", 32'(dutAccepts - a0), 32'd1);
        checkVal("t25/value", 32'(lastAcceptedNum), 32'd25);

        applyStimulus(tensSeg[3], onesSeg[1], 1'b1, 6, "t31");
        checkVal("t31/err", 32'(lastAcceptedErr), 32'd1);
        checkVal("t31/number", 32'(lastAcceptedNum), 32'd0);

        applyStimulus(tensSeg[3], onesSeg[0], 1'b1, 6, "t30");
        checkVal("t30/err", 32'(lastAcceptedErr), 32'd0);
        checkVal("t30/number", 32'(lastAcceptedNum), 32'd30);

        // Glitch 12 -> 17 (2 cycles) -> 12 yields a single transfer
        a0 = dutAccepts;
        applyStimulus(tensSeg[1], onesSeg[2], 1'b1, 6, "glitch");
        applyStimulus(tensSeg[1], onesSeg[7], 1'b1, 2, "glitch");
        applyStimulus(tensSeg[1], onesSeg[2], 1'b1, 6, "glitch");
        checkVal("glitch/transfers", 32'(dutAccepts - a0), 32'd1);
        checkVal("glitch/value", 32'(lastAcceptedNum), 32'd12);

        // Back-pressure: 4 stays displayed, 7 is overwritten by 8
        applyStimulus(tensSeg[0], onesSeg[4], 1'b0, 5, "hold4");
        applyStimulus(tensSeg[0], onesSeg[7], 1'b0, 5, "hold7");
        checkVal("hold/number4a", 32'(out_number), 32'd4);
        applyStimulus(tensSeg[0], onesSeg[8], 1'b0, 5, "hold8");
        checkVal("hold/number4b", 32'(out_number), 32'd4);
        applyStimulus(tensSeg[0], onesSeg[8], 1'b1, 1, "acc");
        checkVal("hold/nextValid", 32'(out_valid), 32'd1);
        checkVal("hold/next8", 32'(out_number), 32'd8);
        applyStimulus(tensSeg[0], onesSeg[8], 1'b1, 2, "drain");

        for (int blk = 0; blk < 80; blk++) begin
            if ($urandom_range(0, 9) < 8) begin
                rt = tensSeg[$urandom_range(0, 3)];
                ro = onesSeg[$urandom_range(0, 9)];
            end else begin
                rt = 7'($urandom);
                ro = 7'($urandom);
            end
            hold = $urandom_range(1, 7);
            for (int c = 0; c < hold; c++) begin
                applyStimulus(rt, ro, 1'($urandom_range(0, 1)), 1, "rand");
            end
        end

        // Asynchronous reset while a result is being held
        applyStimulus(tensSeg[2], onesSeg[1], 1'b0, 6, "preRst");
        checkVal("preRst/valid", 32'(out_valid), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        checkVal("rst/valid", 32'(out_valid), 32'd0);
        checkVal("rst/number", 32'(out_number), 32'd0);
        checkVal("rst/err", 32'(out_err), 32'd0);
        modelReset();
        @(negedge clk);
        reset_n = 1'b1;
        applyStimulus(tensSeg[0], onesSeg[3], 1'b1, 7, "postRst");

`ifdef DECODE_ERR_CNT_EN
        for (int k = 0; k < 300; k++) begin
            if (k % 2 == 0) applyStimulus(tensSeg[0], 7'b0000000, 1'b1, 5, "errA");
            else            applyStimulus(tensSeg[3], onesSeg[1], 1'b1, 5, "errB");
        end
        applyStimulus(tensSeg[3], onesSeg[1], 1'b1, 2, "errEnd");
        checkVal("errcnt/saturated", 32'(err_count), 32'd255);
        #2;
        reset_n = 1'b0;
        #1;
        checkVal("errcnt/reset", 32'(err_count), 32'd0);
        modelReset();
        @(negedge clk);
        reset_n = 1'b1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
